// File: rtl/instruction_sequencer_if.sv
// Program-memory read port and instruction-issue port of the sequencer.
//
// Handshake semantics:
//   mem_req is the request and mem_valid is the response. The sequencer
//   raises mem_req with mem_addr, then holds both stable until it samples
//   mem_valid=1 on a rising edge. mem_rdata is meaningful only on that edge.
//   mem_valid seen while mem_req=0 is ignored.
//   inst_valid is a one-cycle strobe with no back-pressure. The consumer must
//   take inst in the cycle where inst_valid=1.
interface instruction_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic [7:0]        mem_rdata;
    logic              mem_valid;
    logic [7:0]        inst;
    logic              inst_valid;

    modport master (
        output mem_addr,
        output mem_req,
        input  mem_rdata,
        input  mem_valid,
        output inst,
        output inst_valid
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        output mem_rdata,
        output mem_valid,
        input  inst,
        input  inst_valid
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: the front end of the 8-bit core.
// It owns the program counter and fetches one byte per instruction from
// program memory. Each byte is issued for a single cycle. Condition
// instructions (opcode 2'b11) are resolved against reg3 and jump to reg0.
// The block keeps a saturating count of retired instructions. It halts once
// the program counter leaves the program.
module instruction_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int PROG_LEN = 256,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    instruction_sequencer_if.master  bus,
    input  logic [7:0]               cond_value,
    input  logic [7:0]               jump_target,
    output logic [ADDR_W-1:0]        pc,
    output logic                     halted,
    output logic [CNT_W-1:0]         retired,
    output logic [2:0]               state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // A program longer than the address space cannot be left by stepping, so
    // the limit is clamped. A full-size program then wraps and never halts.
    localparam int PC_SPAN  = 1 << ADDR_W;
    localparam int PC_LIMIT = (PROG_LEN < PC_SPAN) ? PROG_LEN : PC_SPAN;
    localparam logic [ADDR_W:0] PC_END = (ADDR_W + 1)'(PC_LIMIT);

    state_t            state;
    logic              mem_req_q;
    logic              inst_valid_q;
    logic [7:0]        inst_q;

    logic              is_cond;
    logic              cond_neg;
    logic              cond_zero;
    logic              cond_true;
    logic [ADDR_W+7:0] target_wide;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;
    logic              out_of_range;
    logic              mem_accept;

    // Evaluate the condition field of the issued byte against signed reg3.
    always_comb begin
        is_cond   = (inst_q[7:6] == 2'b11);
        cond_neg  = cond_value[7];
        cond_zero = (cond_value == 8'h00);
        cond_true = 1'b0;
        case (inst_q[2:0])
            3'b000:  cond_true = 1'b0;
            3'b001:  cond_true = cond_zero;
            3'b010:  cond_true = cond_neg;
            3'b011:  cond_true = cond_neg | cond_zero;
            3'b100:  cond_true = 1'b1;
            3'b101:  cond_true = ~cond_zero;
            3'b110:  cond_true = ~cond_neg;
            3'b111:  cond_true = ~cond_neg & ~cond_zero;
            default: cond_true = 1'b0;
        endcase
    end

    // Compute the program counter that follows the issued instruction.
    // reg0 is zero-extended or truncated to fit the pc width.
    always_comb begin
        target_wide  = {{ADDR_W{1'b0}}, jump_target};
        target       = target_wide[ADDR_W-1:0];
        pc_inc       = pc + 1'b1;
        pc_next      = (is_cond && cond_true) ? target : pc_inc;
        out_of_range = ({1'b0, pc_next} >= PC_END);
    end

    // A response is accepted only while a request is outstanding.
    assign mem_accept = bus.mem_valid & mem_req_q;

    // Sequencer FSM. It updates state and every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            inst_q       <= 8'h00;
            inst_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
            halted       <= 1'b0;
            retired      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_req_q    <= 1'b0;
                    inst_valid_q <= 1'b0;
                    if (run) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    mem_req_q <= 1'b1;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // The request and pc stay put until memory answers.
                    if (mem_accept) begin
                        inst_q       <= bus.mem_rdata;
                        mem_req_q    <= 1'b0;
                        inst_valid_q <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    inst_valid_q <= 1'b0;
                    if (retired != {CNT_W{1'b1}}) begin
                        retired <= retired + 1'b1;
                    end
                    pc <= pc_next;
                    if (out_of_range) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state  <= S_FETCH;
                    end
                end
                S_HALT: begin
                    // Sticky. Only reset leaves this state.
                    halted       <= 1'b1;
                    mem_req_q    <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
                default: begin
                    state        <= S_IDLE;
                    mem_req_q    <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr   = pc;
    assign bus.mem_req    = mem_req_q;
    assign bus.inst       = inst_q;
    assign bus.inst_valid = inst_valid_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer. It runs two instances: a full-size
// program (PROG_LEN=256) and a 4-byte program for the halt behaviour.
// A program-order reference model follows the full-size instance. It checks
// every issued byte, pc, retired count and the request hold.
`timescale 1ns/1ps
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_a = 1'b0;
    logic        run_b = 1'b0;
    logic [7:0]  cond_value = 8'h00;
    logic [7:0]  jump_target = 8'h00;

    logic [7:0]  pc_a, pc_b;
    logic        halted_a, halted_b;
    logic [15:0] retired_a, retired_b;
    logic [2:0]  st_a, st_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    instruction_sequencer_if #(.ADDR_W(8)) bus_a ();
    instruction_sequencer_if #(.ADDR_W(8)) bus_b ();

    instruction_sequencer #(.ADDR_W(8), .PROG_LEN(256), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .run(run_a), .bus(bus_a),
        .cond_value(cond_value), .jump_target(jump_target),
        .pc(pc_a), .halted(halted_a), .retired(retired_a), .state_dbg(st_a)
    );

    instruction_sequencer #(.ADDR_W(8), .PROG_LEN(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .run(run_b), .bus(bus_b),
        .cond_value(cond_value), .jump_target(jump_target),
        .pc(pc_b), .halted(halted_b), .retired(retired_b), .state_dbg(st_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory for instance A: latency is fixed or random per request, with an
    // optional forced mem_valid.
    logic [7:0] mem_a [256];
    int  lat_cfg = 0;
    bit  rand_lat = 1'b0;
    bit  force_valid = 1'b0;
    int  req_cnt = 0;
    int  cur_lat = 0;

    always @(negedge clk) begin
        bus_a.mem_rdata = mem_a[bus_a.mem_addr];
        if (!bus_a.mem_req) begin
            req_cnt = 0;
            bus_a.mem_valid = force_valid;
        end else begin
            if (req_cnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
            bus_a.mem_valid = force_valid || (req_cnt >= cur_lat);
            req_cnt++;
        end
    end

    // Memory for instance B: zero-wait, byte = 8'h10 + address (straight-line code).
    always @(negedge clk) begin
        bus_b.mem_valid = bus_b.mem_req;
        bus_b.mem_rdata = 8'h10 + bus_b.mem_addr;
    end

    // Reference model: the condition rule on a signed integer.
    function automatic bit cond_holds(input logic [2:0] code, input logic [7:0] v);
        int c;
        c = (v >= 8'd128) ? int'(v) - 256 : int'(v);
        case (code)
            3'd0: return 1'b0;
            3'd1: return c == 0;
            3'd2: return c < 0;
            3'd3: return c <= 0;
            3'd4: return 1'b1;
            3'd5: return c != 0;
            3'd6: return c >= 0;
            default: return c > 0;
        endcase
    endfunction

    // Scoreboard for instance A. It follows the program in order.
    int m_pc = 0;
    int m_cnt = 0;
    bit prev_iv = 1'b0;
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        logic [7:0] op;
        if (rst) begin
            m_pc = 0;
            m_cnt = 0;
            prev_iv = 1'b0;
            exp_q.delete();
        end else begin
            if (prev_iv) chk("single_pulse", bus_a.inst_valid, 1'b0);
            if (bus_a.mem_req) chk("req_addr_hold", bus_a.mem_addr, m_pc);
            if (bus_a.inst_valid) begin
                exp_q.push_back(mem_a[m_pc]);
                op = exp_q.pop_front();
                chk("inst", bus_a.inst, op);
                chk("pc_at_issue", pc_a, m_pc);
                chk("retired_at_issue", retired_a, (m_cnt > 65535) ? 65535 : m_cnt);
                chk("req_low_at_issue", bus_a.mem_req, 1'b0);
                chk("not_halted", halted_a, 1'b0);
                if (op[7:6] == 2'b11 && cond_holds(op[2:0], cond_value))
                    m_pc = int'(jump_target);
                else
                    m_pc = (m_pc + 1) % 256;
                m_cnt++;
            end
            prev_iv = bus_a.inst_valid;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_inst"}, bus_a.inst, 8'h00);
        chk({tag, "_inst_valid"}, bus_a.inst_valid, 1'b0);
        chk({tag, "_mem_req"}, bus_a.mem_req, 1'b0);
        chk({tag, "_pc"}, pc_a, 8'h00);
        chk({tag, "_mem_addr"}, bus_a.mem_addr, 8'h00);
        chk({tag, "_halted"}, halted_a, 1'b0);
        chk({tag, "_retired"}, retired_a, 16'h0000);
        chk({tag, "_b_halted"}, halted_b, 1'b0);
        chk({tag, "_b_pc"}, pc_b, 8'h00);
    endtask

    // Returns at the negedge of the next cycle with inst_valid=1.
    task automatic wait_issue(input int budget, output int when);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_a.inst_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("issue_timeout", bus_a.inst_valid, 1'b1);
        when = cyc;
    endtask

    initial begin
        int t0, t1, t2, t3, n, n_req, nb;
        for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;

        // Reset state.
        do_reset();
        check_reset_state("reset");

        // Zero-wait straight-line run: issue every 3 cycles.
        mem_a[0] = 8'h05; mem_a[1] = 8'h86; mem_a[2] = 8'h44;
        @(posedge clk); #1;
        run_a = 1'b1;
        t0 = cyc;
        wait_issue(20, t1);
        chk("first_latency", t1 - t0, 3);
        wait_issue(20, t2);
        chk("gap_1_2", t2 - t1, 3);
        wait_issue(20, t3);
        chk("gap_2_3", t3 - t2, 3);
        chk("third_inst", bus_a.inst, 8'h44);
        @(negedge clk);
        chk("seq_pc", pc_a, 8'h03);
        chk("seq_retired", retired_a, 16'd3);

        // Four extra wait cycles at pc=0: request held, single issue.
        run_a = 1'b0;
        do_reset();
        lat_cfg = 4;
        run_a = 1'b1;
        n = 0; n_req = 0;
        @(negedge clk);
        while (!bus_a.inst_valid && n < 30) begin
            if (bus_a.mem_req) begin
                n_req++;
                chk("wait_addr", bus_a.mem_addr, 8'h00);
            end
            @(negedge clk);
            n++;
        end
        chk("wait_issue_seen", bus_a.inst_valid, 1'b1);
        chk("wait_req_cycles", n_req, 5);
        @(negedge clk);
        chk("wait_no_dup", bus_a.inst_valid, 1'b0);
        lat_cfg = 0;

        // Conditional jumps: taken, not taken, never, always, then a wrap.
        run_a = 1'b0;
        do_reset();
        mem_a[8'h00] = 8'hC2; mem_a[8'h10] = 8'hC2; mem_a[8'h11] = 8'hC0;
        mem_a[8'h12] = 8'hC4; mem_a[8'hFF] = 8'h01;
        cond_value = 8'h80; jump_target = 8'h10;
        run_a = 1'b1;
        wait_issue(20, t1);
        @(posedge clk); #1;
        cond_value = 8'h00;
        @(negedge clk);
        chk("jmp_taken_addr", bus_a.mem_addr, 8'h10);
        wait_issue(20, t1);
        @(negedge clk);
        chk("jmp_not_taken", pc_a, 8'h11);
        wait_issue(20, t1);
        @(posedge clk); #1;
        jump_target = 8'hFF;
        @(negedge clk);
        chk("jmp_never", pc_a, 8'h12);
        wait_issue(20, t1);
        @(negedge clk);
        chk("jmp_always_ff", pc_a, 8'hFF);
        wait_issue(20, t1);
        @(negedge clk);
        chk("pc_wrap", pc_a, 8'h00);

        // Reset lands in WAIT together with mem_valid. Nothing may issue.
        run_a = 1'b0;
        lat_cfg = 20;
        n = 0;
        while (!bus_a.mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wait_entered", bus_a.mem_req, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        force_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        force_valid = 1'b0;
        lat_cfg = 0;
        chk("rst_mid_wait_iv", bus_a.inst_valid, 1'b0);
        check_reset_state("rst_mid_wait");

        // Short program: halt after 4 issues, sticky against run.
        run_b = 1'b1;
        n = 0; nb = 0;
        while (!halted_b && n < 80) begin
            @(negedge clk);
            n++;
            if (bus_b.inst_valid) begin
                chk("b_inst", bus_b.inst, 32'h10 + nb);
                nb++;
            end
        end
        chk("b_halted", halted_b, 1'b1);
        chk("b_issue_count", nb, 4);
        chk("b_pc", pc_b, 8'h04);
        chk("b_mem_req", bus_b.mem_req, 1'b0);
        chk("b_retired", retired_b, 16'd4);
        repeat (6) begin
            @(posedge clk); #1;
            run_b = ~run_b;
        end
        @(negedge clk);
        chk("b_still_halted", halted_b, 1'b1);
        chk("b_still_pc", pc_b, 8'h04);
        chk("b_no_issue", bus_b.inst_valid, 1'b0);
        run_b = 1'b0;
        do_reset();
        check_reset_state("b_reset");

        // Randomized program, operands and memory latency.
        for (int i = 0; i < 256; i++)
            mem_a[i] = ($urandom_range(0, 1) == 1) ? {2'b11, 6'($urandom_range(0, 63))}
                                                    : 8'($urandom_range(0, 255));
        rand_lat = 1'b1;
        run_a = 1'b1;
        for (int k = 0; k < 150; k++) begin
            wait_issue(20, t1);
            @(posedge clk); #1;
            case ($urandom_range(0, 3))
                0: cond_value = 8'h00;
                1: cond_value = 8'h80;
                2: cond_value = 8'h7F;
                default: cond_value = 8'($urandom_range(0, 255));
            endcase
            jump_target = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        chk("random_retired", retired_a, 16'd150);
        rand_lat = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
